reg_file_read_port: RTL and testbench
=====================================

// Module: reg_file_read_port
// PURPOSE
//  Two-operand read front end for the 32x64 register storage array. Samples two
//  source addresses under a valid/ready handshake and returns registered operand
//  data one cycle later. Forwards a same-cycle write so reads never return stale
//  data. Hardwires ZERO_REG to zero. Sits between decode and the ALU operand latches.
// PARAMETERS
//  WIDTH     32  number of registers in the storage array
//  SUBWIDTH  64  bits per register
//  ZERO_REG  31  index that always reads as zero and ignores forwarding
//  AW        $clog2(WIDTH)  address width (derived, not overridden)
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  reset      in   1                  asynchronous, active-low reset
//  mem_q      in   [WIDTH-1:0][SUBWIDTH-1:0]  current contents of storage array
//  wr_en      in   1                  storage write this cycle (commits at next edge)
//  wr_addr    in   AW                 storage write index
//  wr_data    in   SUBWIDTH           storage write data
//  req_valid  in   1                  read request present
//  req_ready  out  1                  port can accept request
//  rs1_addr   in   AW                 operand 1 index
//  rs2_addr   in   AW                 operand 2 index
//  rsp_valid  out  1                  operand data valid
//  rsp_ready  in   1                  consumer accepts operand data
//  rs1_data   out  SUBWIDTH           operand 1 value
//  rs2_data   out  SUBWIDTH           operand 2 value
// BEHAVIOUR
//  - Reset (reset=0, async): rsp_valid=0, rs1_data=rs2_data=0, held addrs=0.
//    An in-flight or stalled response is discarded. req_ready=1 after release.
//  - req_ready = !rsp_valid | rsp_ready (combinational, one-entry output stage).
//  - Accept = req_valid & req_ready. On accept, the next edge sets rsp_valid=1,
//    latches both addrs and loads data. Latency is 1 cycle.
//  - On rsp_valid & rsp_ready with no new accept, the next edge sets rsp_valid=0.
//    Data outputs keep their last value.
//  - Back-to-back operation: accept while the consumer drains keeps rsp_valid=1.
//    New data loads each cycle, giving full throughput.
//  - Operand select per port, in priority order:
//    1) addr==ZERO_REG or addr>=WIDTH -> 0;
//    2) wr_en & wr_addr==addr -> wr_data (bypass);
//    3) else mem_q[addr].
//  - Stall coherence: while rsp_valid & !rsp_ready, the held data follows storage.
//    If wr_en & wr_addr==held addr (not ZERO_REG), the held data is updated to wr_data
//    at that edge. Otherwise the output is stable. Both ports are checked independently.
//  - rs1_addr==rs2_addr is legal. Both outputs are identical, including bypass.
//  - A write to ZERO_REG never changes any output.
//  - No combinational path from mem_q or wr_* to rs*_data. All outputs except
//    req_ready are registered.
// TESTING
//  - Reset: drive reset=0 mid-stall with rsp_valid=1 -> rsp_valid=0 and data=0 at
//    once; after release req_ready=1.
//  - Basic read: mem_q[3]=0xA5, mem_q[7]=0x5A, request (3,7) -> next cycle
//    rsp_valid=1, rs1=0xA5, rs2=0x5A.
//  - Bypass: request (4,4) with wr_en=1, wr_addr=4, wr_data=0x1234, mem_q[4]=0
//    -> rs1=rs2=0x1234.
//  - Zero reg: mem_q[31]=0xFFFF, request (31,2) plus wr_en to 31 -> rs1=0 and
//    rs2=mem_q[2].
//  - Stall: rsp_ready=0 for 3 cycles, wr_en to held rs2 addr with 0xBEEF in cycle 2
//    -> req_ready=0 throughout, rs1 stable, rs2=0xBEEF from cycle 3.
//  - Throughput: 8 consecutive requests with rsp_ready=1 -> 8 consecutive valid
//    responses, in order, no bubbles.

Source files
------------

// File: rtl/reg_file_read_port.sv
// Two-operand register read port with a one-entry registered output stage.
// Forwards same-cycle writes and keeps a stalled response coherent with storage.
module reg_file_read_port #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SUBWIDTH = 64,
    parameter int unsigned ZERO_REG = 31,
    localparam int unsigned AW      = $clog2(WIDTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [WIDTH-1:0][SUBWIDTH-1:0]     mem_q,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [SUBWIDTH-1:0]                wr_data,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [AW-1:0]                      rs1_addr,
    input  logic [AW-1:0]                      rs2_addr,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [SUBWIDTH-1:0]                rs1_data,
    output logic [SUBWIDTH-1:0]                rs2_data
);

    logic [AW-1:0]       rs1_held;
    logic [AW-1:0]       rs2_held;
    logic                rsp_valid_d;
    logic [AW-1:0]       rs1_held_d;
    logic [AW-1:0]       rs2_held_d;
    logic [SUBWIDTH-1:0] rs1_data_d;
    logic [SUBWIDTH-1:0] rs2_data_d;
    logic                accept_c;

    // Index that must read as zero: the hardwired register or anything past the array.
    function automatic logic is_zero(input logic [AW-1:0] addr);
        return (32'(addr) == ZERO_REG) || (32'(addr) >= WIDTH);
    endfunction

    // A write this cycle that lands on a live (non-zero) register index.
    function automatic logic write_hit(input logic [AW-1:0] addr, input logic we,
                                       input logic [AW-1:0] waddr);
        return we && (waddr == addr) && !is_zero(addr);
    endfunction

    function automatic logic [SUBWIDTH-1:0] operand(
        input logic [AW-1:0]                  addr,
        input logic [WIDTH-1:0][SUBWIDTH-1:0] mem,
        input logic                           we,
        input logic [AW-1:0]                  waddr,
        input logic [SUBWIDTH-1:0]            wdata
    );
        if (is_zero(addr))
            return '0;
        else if (write_hit(addr, we, waddr))
            return wdata;
        else
            return mem[addr];
    endfunction

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept_c  = req_valid && req_ready;

    // Next-state: load on accept, drop on drain, track storage writes while stalled.
    always_comb begin
        rsp_valid_d = rsp_valid;
        rs1_held_d  = rs1_held;
        rs2_held_d  = rs2_held;
        rs1_data_d  = rs1_data;
        rs2_data_d  = rs2_data;
        if (accept_c) begin
            rsp_valid_d = 1'b1;
            rs1_held_d  = rs1_addr;
            rs2_held_d  = rs2_addr;
            rs1_data_d  = operand(rs1_addr, mem_q, wr_en, wr_addr, wr_data);
            rs2_data_d  = operand(rs2_addr, mem_q, wr_en, wr_addr, wr_data);
        end else if (rsp_valid) begin
            if (rsp_ready) begin
                rsp_valid_d = 1'b0;
            end else begin
                if (write_hit(rs1_held, wr_en, wr_addr))
                    rs1_data_d = wr_data;
                if (write_hit(rs2_held, wr_en, wr_addr))
                    rs2_data_d = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rs1_held  <= '0;
            rs2_held  <= '0;
            rs1_data  <= '0;
            rs2_data  <= '0;
        end else begin
            rsp_valid <= rsp_valid_d;
            rs1_held  <= rs1_held_d;
            rs2_held  <= rs2_held_d;
            rs1_data  <= rs1_data_d;
            rs2_data  <= rs2_data_d;
        end
    end

endmodule

// File: tb/tb_reg_file_read_port.sv
// Bench for reg_file_read_port: storage model, architectural-value reference model,
// per-cycle compare process and directed vectors with literal expectations.
module tb_reg_file_read_port;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned SUBWIDTH = 64;
    localparam int unsigned ZREG     = 31;
    localparam int unsigned AW       = 5;

    logic                           clk = 1'b0;
    logic                           reset = 1'b1;
    logic [WIDTH-1:0][SUBWIDTH-1:0] mem_q;
    logic                           wr_en = 1'b0;
    logic [AW-1:0]                  wr_addr = '0;
    logic [SUBWIDTH-1:0]            wr_data = '0;
    logic                           req_valid = 1'b0;
    logic                           req_ready;
    logic [AW-1:0]                  rs1_addr = '0;
    logic [AW-1:0]                  rs2_addr = '0;
    logic                           rsp_valid;
    logic                           rsp_ready = 1'b1;
    logic [SUBWIDTH-1:0]            rs1_data;
    logic [SUBWIDTH-1:0]            rs2_data;

    int checks = 0;
    int errors = 0;

    reg_file_read_port dut (
        .clk       (clk),
        .reset     (reset),
        .mem_q     (mem_q),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data)
    );

    always #5 clk = ~clk;

    // Storage array: writes commit at the edge, contents visible on mem_q.
    logic [SUBWIDTH-1:0] store [WIDTH] = '{default: '0};
    always @(posedge clk) if (wr_en) store[wr_addr] <= wr_data;
    always_comb for (int i = 0; i < WIDTH; i++) mem_q[i] = store[i];

    // Architectural value of a register as seen by a reader.
    function automatic logic [SUBWIDTH-1:0] arch(input logic [AW-1:0] a);
        return (32'(a) == ZREG) ? '0 : store[a];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference: a live response always shows the current architectural value of
    // its captured registers; once consumed the outputs freeze.
    logic          m_valid = 1'b0;
    logic [AW-1:0] m_a1 = '0, m_a2 = '0;
    logic [SUBWIDTH-1:0] m_d1 = '0, m_d2 = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
        end else if (req_valid && (!m_valid || rsp_ready)) begin
            m_valid <= 1'b1;
            m_a1    <= rs1_addr;
            m_a2    <= rs2_addr;
        end else if (m_valid && rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            m_d1 = '0;
            m_d2 = '0;
        end else if (m_valid) begin
            m_d1 = arch(m_a1);
            m_d2 = arch(m_a2);
        end
        check("cyc_rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("cyc_req_ready", 64'(req_ready), 64'(!m_valid || rsp_ready));
        check("cyc_rs1_data", rs1_data, m_d1);
        check("cyc_rs2_data", rs2_data, m_d2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic req(input int a1, input int a2);
        req_valid = 1'b1; rs1_addr = AW'(a1); rs2_addr = AW'(a2);
    endtask

    initial begin
        #1 reset = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_ready", 64'(req_ready), 64'd1);

        wr(3, 64'hA5); wr(7, 64'h5A); wr(31, 64'hFFFF); wr(2, 64'h22);
        wr(5, 64'h55); wr(6, 64'h66);
        for (int i = 0; i < 8; i++) wr(8 + i, 64'h1000 + 64'(i));

        // basic read
        req(3, 7); step(); req_valid = 1'b0;
        check("basic_valid", 64'(rsp_valid), 64'd1);
        check("basic_rs1", rs1_data, 64'hA5);
        check("basic_rs2", rs2_data, 64'h5A);
        step();
        check("basic_drain", 64'(rsp_valid), 64'd0);
        check("basic_hold", rs1_data, 64'hA5);

        // bypass of a same-cycle write, identical addresses
        req(4, 4); wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h1234;
        step(); req_valid = 1'b0; wr_en = 1'b0;
        check("bypass_rs1", rs1_data, 64'h1234);
        check("bypass_rs2", rs2_data, 64'h1234);

        // zero register ignores storage and forwarding
        req(31, 2); wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hDEAD;
        step(); req_valid = 1'b0; wr_en = 1'b0;
        check("zero_rs1", rs1_data, 64'h0);
        check("zero_rs2", rs2_data, 64'h22);
        step();

        // stall with a write to the held rs2 address in the second cycle
        req(3, 7); step();
        req(5, 6); rsp_ready = 1'b0;
        #1;
        check("stall1_ready", 64'(req_ready), 64'd0);
        step();
        check("stall1_rs1", rs1_data, 64'hA5);
        check("stall1_rs2", rs2_data, 64'h5A);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hBEEF;
        step(); wr_en = 1'b0;
        check("stall2_rs1", rs1_data, 64'hA5);
        check("stall2_rs2", rs2_data, 64'hBEEF);
        check("stall2_ready", 64'(req_ready), 64'd0);
        step();
        check("stall3_rs1", rs1_data, 64'hA5);
        check("stall3_rs2", rs2_data, 64'hBEEF);
        check("stall3_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        step(); req_valid = 1'b0;
        check("after_stall_rs1", rs1_data, 64'h55);
        check("after_stall_rs2", rs2_data, 64'h66);
        step();

        // full-throughput sequence
        for (int i = 0; i < 8; i++) begin
            req(8 + i, 15 - i);
            step();
            check("tput_valid", 64'(rsp_valid), 64'd1);
            check("tput_rs1", rs1_data, 64'h1000 + 64'(i));
            check("tput_rs2", rs2_data, 64'h1000 + 64'(7 - i));
        end
        req_valid = 1'b0;
        step();
        check("tput_drain", 64'(rsp_valid), 64'd0);

        // asynchronous reset in the middle of a stall
        req(3, 2); step(); req_valid = 1'b0; rsp_ready = 1'b0;
        step();
        check("pre_reset_valid", 64'(rsp_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("async_valid", 64'(rsp_valid), 64'd0);
        check("async_rs1", rs1_data, 64'h0);
        check("async_rs2", rs2_data, 64'h0);
        step();
        reset = 1'b1;
        #1;
        check("release_ready", 64'(req_ready), 64'd1);
        rsp_ready = 1'b1;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
